tournament_update_ctrl: RTL

Sequences branch-resolution updates into the tournament predictor's single-ported 2-bit counter table and shares that port with front-end prediction lookups. Resolved branches are buffered in a small FIFO and retired one at a time as a read-modify-write of the saturating counter. Lookups have priority, and updates use idle port cycles. An optional starvation guard bounds how long lookups can block an update.

---
 rtl/tournament_update_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/tournament_update_ctrl.sv
// tournament_update_ctrl: queues branch-resolution updates and retires them as
// read-modify-writes of 2-bit counters. The table port is shared with lookups,
// and lookups have priority.
// Optional macro TOURN_UPD_STARVE_GUARD_EN: after STARVE_LIMIT blocked cycles,
// the next cycle that needs the port is granted to the update FSM.
module tournament_update_ctrl #(
   parameter int IDX_W        = 10,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         lookup_valid,
   input  logic [IDX_W-1:0]             lookup_idx,
   output logic                         lookup_ready,
   input  logic                         upd_valid,
   input  logic [IDX_W-1:0]             upd_idx,
   input  logic                         upd_taken,
   output logic                         upd_ready,
   output logic                         tbl_en,
   output logic                         tbl_we,
   output logic [IDX_W-1:0]             tbl_addr,
   output logic [1:0]                   tbl_wdata,
   input  logic [1:0]                   tbl_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   pending,
   output logic                         busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

   state_t            state_q;
   logic [1:0]        val_q, val_d;
   logic [IDX_W-1:0]  idx_q [DEPTH];
   logic              tkn_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              push, pop, need_port, force_gnt, fsm_gnt;
   logic [IDX_W-1:0]  head_idx;
   logic              head_tkn;

   assign head_idx  = idx_q[rd_ptr_q];
   assign head_tkn  = tkn_q[rd_ptr_q];
   assign upd_ready = cnt_q != FULL;
   assign push      = upd_valid && upd_ready;
   assign need_port = (state_q == S_IDLE && cnt_q != '0) || state_q == S_WRITE;
   assign fsm_gnt   = need_port && !lookup_ready;
   assign pop       = fsm_gnt && state_q == S_WRITE;
   assign pending   = cnt_q;
   assign busy      = state_q != S_IDLE || cnt_q != '0;

`ifdef TOURN_UPD_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT+1);
   logic [SW-1:0] starve_q;
   assign force_gnt = need_port && starve_q >= SW'(STARVE_LIMIT);
   // Count cycles a lookup steals the port from pending work; any FSM grant clears it.
   always_ff @(posedge clock or posedge reset)
      if (reset) starve_q <= '0;
      else if (fsm_gnt) starve_q <= '0;
      else if (need_port && lookup_valid) starve_q <= starve_q + 1'b1;
`else
   assign force_gnt = 1'b0;
`endif

   assign lookup_ready = lookup_valid && !force_gnt;

   // Saturating counter step applied to the value read back in WAIT.
   always_comb begin
      val_d = tbl_rdata;
      if (head_tkn && tbl_rdata != 2'd3) val_d = tbl_rdata + 2'd1;
      if (!head_tkn && tbl_rdata != 2'd0) val_d = tbl_rdata - 2'd1;
   end

   // Port mux: lookup first, then the FSM read (IDLE) or write (WRITE), else quiet.
   always_comb begin
      tbl_en    = lookup_ready || fsm_gnt;
      tbl_we    = !lookup_ready && fsm_gnt && state_q == S_WRITE;
      tbl_addr  = lookup_ready ? lookup_idx : (fsm_gnt ? head_idx : '0);
      tbl_wdata = tbl_we ? val_q : 2'd0;
   end

   // FIFO payload storage; contents are meaningless while the slot is empty.
   always_ff @(posedge clock)
      if (push) begin
         idx_q[wr_ptr_q] <= upd_idx;
         tkn_q[wr_ptr_q] <= upd_taken;
      end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end

   // Read-modify-write sequencer: read head, capture new value, write it back and pop.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q <= S_IDLE;
         val_q   <= 2'd0;
      end else begin
         case (state_q)
            S_IDLE:  if (fsm_gnt) state_q <= S_WAIT;
            S_WAIT:  begin
               val_q   <= val_d;
               state_q <= S_WRITE;
            end
            S_WRITE: if (fsm_gnt) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
endmodule
